// File: rtl/multiport_regfile.sv
// Parametrised register file with one write port and NUM_READ independent read ports.
// It supports optional registered reads, write-to-read bypass, a hardwired zero register and synchronous clear.
module multiport_regfile #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  parameter int REG_READ   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [NUM_READ-1:0]            rd_en,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ-1:0]            rd_valid
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = '1;

  generate
    if (NUM_READ < 1 || NUM_READ > 4 || ADDR_WIDTH < 1 || DATA_WIDTH < 1) begin : g_param_check
      $error("multiport_regfile: NUM_READ must be 1..4, ADDR_WIDTH and DATA_WIDTH must be >= 1");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] regs_reg [DEPTH];
  logic                  wr_allowed;

  // Writes to the zero register are dropped so the array slot itself stays 0.
  assign wr_allowed = wr_en && !((ZERO_REG == 1) && (wr_addr == TOP_ADDR));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_allowed) begin
      regs_reg[wr_addr] <= wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_port
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] value;

      assign addr = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];

      // Priority: zero register, then bypass, then the array contents.
      always_comb begin
        value = regs_reg[addr];
        if ((BYPASS == 1) && wr_en && (wr_addr == addr)) begin
          value = wr_data;
        end
        if ((ZERO_REG == 1) && (addr == TOP_ADDR)) begin
          value = '0;
        end
      end

      if (REG_READ == 1) begin : g_reg
        logic [DATA_WIDTH-1:0] data_reg;
        logic                  valid_reg;

        always_ff @(posedge clk) begin
          if (!reset_n) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
          end else if (rd_en[gi]) begin
            data_reg  <= value;
            valid_reg <= 1'b1;
          end else begin
            valid_reg <= 1'b0;
          end
        end

        assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = data_reg;
        assign rd_valid[gi]                         = valid_reg;
      end else begin : g_comb
        assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = value;
        assign rd_valid[gi]                         = rd_en[gi];
      end
    end
  endgenerate

endmodule

// File: tb/tb_multiport_regfile.sv
// Scoreboard bench: a default-parameter instance (registered reads) and a 3-port, 16 x 32 combinational
// instance without bypass or zero register share one directed stimulus stream.
module tb_multiport_regfile;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [63:0]  wr_data;
  logic [1:0]   rd_en;
  logic [9:0]   rd_addr;
  logic [127:0] rd_data;
  logic [1:0]   rd_valid;

  logic [3:0]   s_wr_addr;
  logic [31:0]  s_wr_data;
  logic [2:0]   s_rd_en;
  logic [11:0]  s_rd_addr;
  logic [95:0]  s_rd_data;
  logic [2:0]   s_rd_valid;

  multiport_regfile dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  multiport_regfile #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_READ(3), .ZERO_REG(0), .REG_READ(0), .BYPASS(0)
  ) dut_small (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_valid(s_rd_valid)
  );

  typedef struct packed {
    logic [1:0]   valid;
    logic [127:0] data;
  } big_exp_t;

  typedef struct packed {
    logic [2:0]  valid;
    logic [95:0] data;
  } small_exp_t;

  big_exp_t   big_q[$];
  small_exp_t small_q[$];

  logic [63:0] big_mem [32];
  logic [63:0] big_last [2];
  logic [31:0] small_mem [16];

  int tests    = 0;
  int failures = 0;

  task automatic step(input logic rst, input logic we, input logic [4:0] wa, input logic [63:0] wd,
                      input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1);
    big_exp_t   be;
    small_exp_t se;
    logic [4:0] ba [2];
    logic [3:0] sa [3];
    logic [2:0] sre;
    logic [63:0] v;
    @(negedge clk);
    reset_n = ~rst;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = re;
    rd_addr = {a1, a0};
    ba[0] = a0;
    ba[1] = a1;
    sa[0] = a0[3:0];
    sa[1] = a1[3:0];
    sa[2] = a0[3:0];
    sre = rst ? 3'b000 : {re[0], re[1], re[0]};
    s_wr_addr = wa[3:0];
    s_wr_data = wd[31:0];
    s_rd_en   = sre;
    s_rd_addr = {sa[2], sa[1], sa[0]};

    // Registered instance: result appears after the coming edge.
    for (int p = 0; p < 2; p++) begin
      if (rst) begin
        big_last[p] = 64'h0;
        be.valid[p] = 1'b0;
      end else if (re[p]) begin
        if (ba[p] == 5'd31)            v = 64'h0;
        else if (we && wa == ba[p])    v = wd;
        else                           v = big_mem[ba[p]];
        big_last[p] = v;
        be.valid[p] = 1'b1;
      end else begin
        be.valid[p] = 1'b0;
      end
      be.data[p*64 +: 64] = big_last[p];
    end
    big_q.push_back(be);

    // Combinational instance without bypass: old array contents, valid mirrors rd_en.
    for (int p = 0; p < 3; p++) begin
      se.valid[p]         = sre[p];
      se.data[p*32 +: 32] = small_mem[sa[p]];
    end
    small_q.push_back(se);

    if (rst) begin
      for (int i = 0; i < 32; i++) big_mem[i] = 64'h0;
      for (int i = 0; i < 16; i++) small_mem[i] = 32'h0;
    end else if (we) begin
      if (wa != 5'd31) big_mem[wa] = wd;
      small_mem[wa[3:0]] = wd[31:0];
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (big_q.size() != 0) begin
      big_exp_t e;
      e = big_q.pop_front();
      for (int p = 0; p < 2; p++) begin
        tests++;
        if (rd_valid[p] !== e.valid[p] || rd_data[p*64 +: 64] !== e.data[p*64 +: 64]) begin
          failures++;
          $display("FAIL big_port%0d: got valid=%b data=%h, expected valid=%b data=%h",
                   p, rd_valid[p], rd_data[p*64 +: 64], e.valid[p], e.data[p*64 +: 64]);
        end else begin
          $display("[TB] big_port%0d ok valid=%b data=%h", p, rd_valid[p], rd_data[p*64 +: 64]);
        end
      end
    end
  end

  always @(negedge clk) begin
    #4;
    if (small_q.size() != 0) begin
      small_exp_t e;
      e = small_q.pop_front();
      for (int p = 0; p < 3; p++) begin
        tests++;
        if (s_rd_valid[p] !== e.valid[p] || s_rd_data[p*32 +: 32] !== e.data[p*32 +: 32]) begin
          failures++;
          $display("FAIL small_port%0d: got valid=%b data=%h, expected valid=%b data=%h",
                   p, s_rd_valid[p], s_rd_data[p*32 +: 32], e.valid[p], e.data[p*32 +: 32]);
        end else begin
          $display("[TB] small_port%0d ok valid=%b data=%h", p, s_rd_valid[p], s_rd_data[p*32 +: 32]);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = '0; rd_addr = '0;
    s_wr_addr = '0; s_wr_data = '0; s_rd_en = '0; s_rd_addr = '0;
    for (int i = 0; i < 32; i++) big_mem[i] = 64'h0;
    for (int i = 0; i < 16; i++) small_mem[i] = 32'h0;
    big_last[0] = 64'h0;
    big_last[1] = 64'h0;

    step(1, 0, 0, 0, 2'b00, 0, 0);
    step(1, 0, 0, 0, 2'b00, 0, 0);
    // Reset clears a written register; reads during reset are ignored.
    step(0, 1, 3, 64'hDEAD, 2'b00, 0, 0);
    step(1, 0, 0, 0, 2'b11, 3, 3);
    step(0, 0, 0, 0, 2'b11, 3, 3);
    // Write then read on every port.
    step(0, 1, 5, 64'h1234_5678_9ABC_DEF0, 2'b00, 0, 0);
    step(0, 0, 0, 0, 2'b11, 5, 5);
    // Same-cycle write/read of X7 while port 1 reads X6.
    step(0, 1, 7, 64'h11, 2'b00, 0, 0);
    step(0, 1, 7, 64'h22, 2'b11, 7, 6);
    step(0, 0, 0, 0, 2'b11, 7, 7);
    // Top register: zero on the default instance, ordinary storage on the small one.
    step(0, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 31, 31);
    step(0, 0, 0, 0, 2'b11, 31, 31);
    // Hold: port 1 idle, then both idle, then read X9.
    step(0, 1, 9, 64'h9, 2'b01, 5, 0);
    step(0, 0, 0, 0, 2'b00, 5, 5);
    step(0, 0, 0, 0, 2'b11, 9, 9);
    // Back-to-back reads with a one-cycle reset in the middle.
    step(0, 1, 10, 64'hAA, 2'b11, 5, 9);
    step(0, 0, 0, 0, 2'b11, 10, 5);
    step(1, 0, 0, 0, 2'b11, 5, 9);
    step(0, 0, 0, 0, 2'b11, 5, 9);
    step(0, 0, 0, 0, 2'b11, 10, 3);
    // Storage works again after reset.
    step(0, 1, 2, 64'hBEEF, 2'b11, 2, 2);
    step(0, 0, 0, 0, 2'b11, 2, 2);
    step(0, 0, 0, 0, 2'b00, 0, 0);

    repeat (3) @(negedge clk);
    tests++;
    if (big_q.size() != 0 || small_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d/%0d entries left, expected 0/0", big_q.size(), small_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
